postfix_arb: RTL and testbench

- Front-end controller that shares one postfix evaluator (4-bit tokens, OP_MODE, 16-bit result, 10-entry stack) between two requesters.
- Each requester streams one postfix expression. The block collects it into a token buffer and checks stack depth, then replays it to the evaluator as one gap-free burst.
- It then captures the evaluator's result and returns it tagged with the requester ID. Arbitration is round-robin.

---
 rtl/postfix_pkg.sv | 32 +++
 rtl/postfix_tok_buf.sv | 48 ++++
 rtl/postfix_arb.sv | 180 ++++++++++++++++++
 tb/tb_postfix_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/postfix_pkg.sv
// Shared types and constants for the postfix evaluator front-end arbiter.
package postfix_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      ISSUE   = 3'd2,
      WAIT    = 3'd3,
      RESP    = 3'd4
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0100;

   localparam int MAX_TOK_DEF     = 16;
   localparam int STACK_DEPTH_DEF = 10;
   localparam int TIMEOUT_DEF     = 15;

   typedef struct packed {
      logic       op;
      logic [3:0] val;
   } tok_t;

   function automatic logic is_valid_op(input logic [3:0] code);
      case (code)
         OP_ADD, OP_SUB, OP_MUL: is_valid_op = 1'b1;
         default:                is_valid_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/postfix_tok_buf.sv
// Sequential-write / sequential-read token store holding one expression.
// count is the number of tokens written since the last clear.
module postfix_tok_buf
   import postfix_pkg::*;
#(
   parameter  int MAX_TOK = MAX_TOK_DEF,
   localparam int CW      = $clog2(MAX_TOK + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  tok_t          wr_data,
   input  logic          rd_en,
   output tok_t          rd_data,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          empty
);
   localparam int AW = $clog2(MAX_TOK);

   tok_t          mem [MAX_TOK];
   logic [CW-1:0] rd_ptr;
   logic          wr_ok;

   assign wr_ok   = wr_en && (count != CW'(MAX_TOK));
   assign empty   = (rd_ptr == count);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // write and read pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         count  <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) count <= count + 1'b1;
         if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage needs no reset; only entries below count are ever read
   always_ff @(posedge clk) begin
      if (wr_ok) mem[count[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/postfix_arb.sv
// Two-requester round-robin front-end for a shared postfix evaluator.
// Optional WAIT timeout is compiled in with `define POSTFIX_ARB_TIMEOUT_EN.
module postfix_arb
   import postfix_pkg::*;
#(
   parameter int MAX_TOK     = MAX_TOK_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [1:0]  REQ_VALID,
   input  logic [1:0]  REQ_OP,
   input  logic [7:0]  REQ_TOK,
   input  logic [1:0]  REQ_LAST,
   output logic [1:0]  REQ_READY,
   output logic        EV_IN_VALID,
   output logic        EV_OP_MODE,
   output logic [3:0]  EV_IN,
   input  logic        EV_OUT_VALID,
   input  logic [15:0] EV_OUT,
   output logic        RSP_VALID,
   output logic        RSP_ID,
   output logic [15:0] RSP_DATA,
   output logic        RSP_ERR
);
   localparam int CW = $clog2(MAX_TOK + 1);
   localparam int DW = $clog2(STACK_DEPTH + 1);

   state_t        state;
   logic          g, ptr, err;
   logic [DW-1:0] depth, depth_nxt;
   logic [CW-1:0] tok_cnt, iss_cnt, buf_count;
   tok_t          in_tok, rd_tok;
   logic          in_last, accept, tok_err, gsel;
   logic          wr_en, rd_en, clr, buf_empty;

`ifdef POSTFIX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wait_cnt;
`else
   localparam int unused_timeout = TIMEOUT;
`endif

   // classify the granted requester's token against the running stack depth
   always_comb begin
      gsel       = REQ_VALID[ptr] ? ptr : ~ptr;
      in_tok.op  = REQ_OP[g];
      in_tok.val = g ? REQ_TOK[7:4] : REQ_TOK[3:0];
      in_last    = REQ_LAST[g];
      accept     = (state == COLLECT) && REQ_VALID[g];
      tok_err    = 1'b0;
      depth_nxt  = depth;
      if (tok_cnt == CW'(MAX_TOK)) begin
         tok_err = 1'b1;
      end else if (!in_tok.op) begin
         if (depth == DW'(STACK_DEPTH)) tok_err = 1'b1;
         else depth_nxt = depth + 1'b1;
      end else begin
         if (!is_valid_op(in_tok.val) || (depth < DW'(2))) tok_err = 1'b1;
         else depth_nxt = depth - 1'b1;
      end
      wr_en = accept && !tok_err;
   end

   assign rd_en = (state == ISSUE) && !buf_empty;
   assign clr   = (state == RESP);

   postfix_tok_buf #(.MAX_TOK(MAX_TOK)) u_buf (
      .clk     (CLK),
      .rst     (RESET),
      .wr_en   (wr_en),
      .wr_data (in_tok),
      .rd_en   (rd_en),
      .rd_data (rd_tok),
      .clr     (clr),
      .count   (buf_count),
      .empty   (buf_empty)
   );

   // control FSM with registered outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         g           <= 1'b0;
         ptr         <= 1'b0;
         err         <= 1'b0;
         depth       <= '0;
         tok_cnt     <= '0;
         iss_cnt     <= '0;
         REQ_READY   <= 2'b00;
         EV_IN_VALID <= 1'b0;
         EV_OP_MODE  <= 1'b0;
         EV_IN       <= 4'd0;
         RSP_VALID   <= 1'b0;
         RSP_ID      <= 1'b0;
         RSP_DATA    <= 16'd0;
         RSP_ERR     <= 1'b0;
`ifdef POSTFIX_ARB_TIMEOUT_EN
         wait_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (REQ_VALID != 2'b00) begin
                  g         <= gsel;
                  REQ_READY <= gsel ? 2'b10 : 2'b01;
                  state     <= COLLECT;
               end
            end
            COLLECT: begin
               if (accept) begin
                  if (tok_cnt != CW'(MAX_TOK)) tok_cnt <= tok_cnt + 1'b1;
                  depth <= depth_nxt;
                  if (in_last) begin
                     REQ_READY <= 2'b00;
                     if (err || tok_err || (depth_nxt != DW'(1))) begin
                        state     <= RESP;
                        RSP_VALID <= 1'b1;
                        RSP_ID    <= g;
                        RSP_DATA  <= 16'd0;
                        RSP_ERR   <= 1'b1;
                     end else begin
                        iss_cnt <= '0;
                        state   <= ISSUE;
                     end
                  end else begin
                     err <= err | tok_err;
                  end
               end
            end
            ISSUE: begin
               EV_IN_VALID <= 1'b1;
               EV_OP_MODE  <= rd_tok.op;
               EV_IN       <= rd_tok.val;
               iss_cnt     <= iss_cnt + 1'b1;
               if (iss_cnt == (buf_count - 1'b1)) state <= WAIT;
            end
            WAIT: begin
               EV_IN_VALID <= 1'b0;
               EV_OP_MODE  <= 1'b0;
               EV_IN       <= 4'd0;
               if (EV_OUT_VALID) begin
                  state     <= RESP;
                  RSP_VALID <= 1'b1;
                  RSP_ID    <= g;
                  RSP_DATA  <= EV_OUT;
                  RSP_ERR   <= 1'b0;
`ifdef POSTFIX_ARB_TIMEOUT_EN
               end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                  state     <= RESP;
                  RSP_VALID <= 1'b1;
                  RSP_ID    <= g;
                  RSP_DATA  <= 16'd0;
                  RSP_ERR   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            RESP: begin
               RSP_VALID <= 1'b0;
               RSP_ID    <= 1'b0;
               RSP_DATA  <= 16'd0;
               RSP_ERR   <= 1'b0;
               ptr       <= ~g;
               err       <= 1'b0;
               depth     <= '0;
               tok_cnt   <= '0;
`ifdef POSTFIX_ARB_TIMEOUT_EN
               wait_cnt  <= '0;
`endif
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_postfix_arb.sv
// Scoreboard bench for postfix_arb with a behavioural evaluator model.
// The timeout scenario runs only when POSTFIX_ARB_TIMEOUT_EN is defined.
module tb_postfix_arb;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [1:0]  REQ_VALID, REQ_OP, REQ_LAST, REQ_READY;
   logic [7:0]  REQ_TOK;
   logic        EV_IN_VALID, EV_OP_MODE, EV_OUT_VALID;
   logic [3:0]  EV_IN;
   logic [15:0] EV_OUT, RSP_DATA;
   logic        RSP_VALID, RSP_ID, RSP_ERR;

   logic       v [2];
   logic       o [2];
   logic       l [2];
   logic [3:0] tk [2];

   typedef struct {
      logic        id;
      logic [15:0] data;
      logic        err;
   } rsp_t;

   rsp_t       exp_q [$];
   int         blen_q [$];
   logic [4:0] sq0 [$];
   logic [4:0] sq1 [$];
   int         checks = 0;
   int         fails  = 0;
   logic       mute   = 1'b0;

   assign REQ_VALID = {v[1], v[0]};
   assign REQ_OP    = {o[1], o[0]};
   assign REQ_LAST  = {l[1], l[0]};
   assign REQ_TOK   = {tk[1], tk[0]};

   always #5 CLK = ~CLK;

   postfix_arb dut (
      .CLK(CLK), .RESET(RESET),
      .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP), .REQ_TOK(REQ_TOK), .REQ_LAST(REQ_LAST),
      .REQ_READY(REQ_READY),
      .EV_IN_VALID(EV_IN_VALID), .EV_OP_MODE(EV_OP_MODE), .EV_IN(EV_IN),
      .EV_OUT_VALID(EV_OUT_VALID), .EV_OUT(EV_OUT),
      .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic tok(input int r, input logic op, input logic [3:0] val);
      if (r == 0) sq0.push_back({op, val});
      else        sq1.push_back({op, val});
   endtask

   task automatic expect_rsp(input logic id, input logic [15:0] data, input logic err);
      rsp_t e;
      e.id = id; e.data = data; e.err = err;
      exp_q.push_back(e);
   endtask

   // stream the queued tokens of requester r, optional bubble before token gap_at
   task automatic send(input int r, input int gap_at, input int gap_len);
      logic [4:0] s [$];
      int n;
      if (r == 0) begin s = sq0; sq0.delete(); end
      else        begin s = sq1; sq1.delete(); end
      for (int i = 0; i < s.size(); i++) begin
         if (i == gap_at) begin
            v[r] = 1'b0;
            repeat (gap_len) @(negedge CLK);
         end
         v[r]  = 1'b1;
         o[r]  = s[i][4];
         tk[r] = s[i][3:0];
         l[r]  = (i == s.size() - 1);
         n = 0;
         while (!REQ_READY[r] && n < 200) begin
            @(negedge CLK);
            n++;
         end
         if (n >= 200) begin
            chk("ready_timeout", 32'd0, 32'd1);
            v[r] = 1'b0; l[r] = 1'b0;
            return;
         end
         @(negedge CLK);
      end
      v[r] = 1'b0;
      l[r] = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      chk("reset_req_ready", REQ_READY, 0);
      chk("reset_ev_in_valid", EV_IN_VALID, 0);
      chk("reset_ev_in", EV_IN, 0);
      chk("reset_rsp_valid", RSP_VALID, 0);
      chk("reset_rsp_data", RSP_DATA, 0);
      RESET = 1'b0;
      @(negedge CLK);
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 400) chk("response_timeout", exp_q.size(), 0);
      repeat (3) @(negedge CLK);
   endtask

   // response monitor: pop and compare on every strobe
   initial begin
      rsp_t e;
      forever begin
         @(negedge CLK);
         if (RSP_VALID) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id", RSP_ID, e.id);
               chk("rsp_data", RSP_DATA, e.data);
               chk("rsp_err", RSP_ERR, e.err);
            end
         end
      end
   end

   // evaluator model: stack machine, answers two cycles after a burst ends
   initial begin
      logic [15:0] stk [$];
      logic [15:0] a, b;
      int   blen = 0, pend = 0, x;
      logic inb = 1'b0;
      EV_OUT_VALID = 1'b0;
      EV_OUT       = 16'd0;
      forever begin
         @(negedge CLK);
         EV_OUT_VALID = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0 && !mute && stk.size() > 0) begin
               EV_OUT_VALID = 1'b1;
               EV_OUT       = stk[stk.size()-1];
            end
         end
         if (EV_IN_VALID) begin
            if (!inb) begin stk.delete(); blen = 0; inb = 1'b1; end
            blen++;
            if (EV_OP_MODE) begin
               if (stk.size() < 2) begin
                  stk.push_back(16'd0);
               end else begin
                  a = stk.pop_back();
                  b = stk.pop_back();
                  case (EV_IN)
                     4'b0001: stk.push_back(b + a);
                     4'b0010: stk.push_back(b - a);
                     4'b0100: stk.push_back(b * a);
                     default: stk.push_back(16'd0);
                  endcase
               end
            end else begin
               stk.push_back({12'd0, EV_IN});
            end
         end else if (inb) begin
            inb  = 1'b0;
            pend = 2;
            if (blen_q.size() == 0) begin
               chk("burst_unexpected", blen, 0);
            end else begin
               x = blen_q.pop_front();
               if (x >= 0) chk("burst_len", blen, x);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 2; i++) begin
         v[i] = 1'b0; o[i] = 1'b0; l[i] = 1'b0; tk[i] = 4'd0;
      end
      do_reset();

      // (3+4)*2 from R0
      tok(0,0,3); tok(0,0,4); tok(0,1,4'b0001); tok(0,0,2); tok(0,1,4'b0100);
      expect_rsp(1'b0, 16'd14, 1'b0); blen_q.push_back(5);
      send(0, -1, 0);
      wait_done();

      // simultaneous pair from reset: R0 then R1
      do_reset();
      tok(0,0,1); tok(0,0,2); tok(0,1,4'b0001);
      tok(1,0,5); tok(1,0,6); tok(1,1,4'b0100);
      expect_rsp(1'b0, 16'd3, 1'b0);  blen_q.push_back(3);
      expect_rsp(1'b1, 16'd30, 1'b0); blen_q.push_back(3);
      fork
         send(0, -1, 0);
         send(1, -1, 0);
      join
      wait_done();

      // underflow from R1: no burst, error response
      tok(1,0,5); tok(1,1,4'b0001);
      expect_rsp(1'b1, 16'd0, 1'b1);
      send(1, -1, 0);
      wait_done();

      // bubbles during collect, gap-free 3-token burst
      tok(0,0,9); tok(0,0,7); tok(0,1,4'b0010);
      expect_rsp(1'b0, 16'd2, 1'b0); blen_q.push_back(3);
      send(0, 1, 3);
      wait_done();

      // pointer now favours R1; 2-3 wraps modulo 2^16
      tok(0,0,8); tok(0,0,8); tok(0,1,4'b0001);
      tok(1,0,2); tok(1,0,3); tok(1,1,4'b0010);
      expect_rsp(1'b1, 16'hFFFF, 1'b0); blen_q.push_back(3);
      expect_rsp(1'b0, 16'd16, 1'b0);   blen_q.push_back(3);
      fork
         send(0, -1, 0);
         send(1, -1, 0);
      join
      wait_done();

      // stack overflow at the 11th operand
      for (int i = 1; i <= 11; i++) tok(1, 1'b0, 4'(i));
      tok(1,1,4'b0001);
      expect_rsp(1'b1, 16'd0, 1'b1);
      send(1, -1, 0);
      wait_done();

      // unsupported operator code
      tok(0,0,3); tok(0,0,4); tok(0,1,4'b0011);
      expect_rsp(1'b0, 16'd0, 1'b1);
      send(0, -1, 0);
      wait_done();

`ifdef POSTFIX_ARB_TIMEOUT_EN
      // evaluator silent: error after the WAIT budget
      mute = 1'b1;
      tok(1,0,3);
      expect_rsp(1'b1, 16'd0, 1'b1); blen_q.push_back(1);
      send(1, -1, 0);
      wait_done();
      mute = 1'b0;
`endif

      // reset mid-issue: valid drops at once, late result ignored
      tok(0,0,3); tok(0,0,4); tok(0,1,4'b0001);
      blen_q.push_back(-1);
      send(0, -1, 0);
      n = 0;
      while (!EV_IN_VALID && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("issue_reached", EV_IN_VALID, 1);
      #2;
      RESET = 1'b1;
      #1;
      chk("reset_drops_ev_in_valid", EV_IN_VALID, 0);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      repeat (15) @(negedge CLK);

      chk("exp_queue_drained", exp_q.size(), 0);
      chk("burst_queue_drained", blen_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
